// File: rtl/alu_add_seq.sv
// alu_add_seq: sequences ADD/SUB/ADC/SBB (16-bit) and ADD32/SUB32 (two
// passes) through an external 16-bit adder and returns registered
// result + C/Z/N/V/err flags.
// Ports: clk, rst_n (async low); req_valid/req_ready/req_op/req_a/req_b;
//   add_in0/add_in1/add_cin -> adder, add_sum/add_cout <- adder;
//   rsp_valid/rsp_ready/rsp_result/rsp_c/rsp_z/rsp_n/rsp_v/rsp_err.
// Macro ALU_ADD_SEQ_SAT_EN enables ops 110 ADDS16 / 111 SUBS16.
module alu_add_seq #(
    parameter logic CFLAG_INIT = 1'b0,
    parameter logic SUB_BORROW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [15:0] add_in0,
    output logic [15:0] add_in1,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_c,
    output logic        rsp_z,
    output logic        rsp_n,
    output logic        rsp_v,
    output logic        rsp_err
);

`ifdef ALU_ADD_SEQ_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC_LO,
        S_EXEC_HI,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [15:0] r_lo_sum;
    logic        r_lo_cout;
    logic        r_cflag;
    logic [31:0] r_result;
    logic        r_c;
    logic        r_z;
    logic        r_n;
    logic        r_v;
    logic        r_err;

    logic        w_req_legal;
    logic        w_sub;
    logic        w_wide;
    logic        w_sat;
    logic        w_cin_lo;
    logic        w_v_raw;
    logic        w_c;
    logic [15:0] w_res16;

    // 11x is only legal when saturating ops are built in.
    assign w_req_legal = ~(req_op[2] & req_op[1]) | SAT_EN;

    // Every subtracting opcode has bit 0 set.
    assign w_sub  = r_op[0];
    assign w_wide = r_op[2] & ~r_op[1];
    assign w_sat  = r_op[2] & r_op[1] & SAT_EN;

    always_comb begin
        w_cin_lo = r_op[0];
        case (r_op)
            3'b010:  w_cin_lo = r_cflag;
            3'b011:  w_cin_lo = r_cflag ^ SUB_BORROW;
            default: w_cin_lo = r_op[0];
        endcase
    end

    always_comb begin
        add_in0 = 16'h0000;
        add_in1 = 16'h0000;
        add_cin = 1'b0;
        case (r_state)
            S_EXEC_LO: begin
                add_in0 = r_a[15:0];
                add_in1 = r_b[15:0] ^ {16{w_sub}};
                add_cin = w_cin_lo;
            end
            S_EXEC_HI: begin
                add_in0 = r_a[31:16];
                add_in1 = r_b[31:16] ^ {16{w_sub}};
                add_cin = r_lo_cout;
            end
            default: ;
        endcase
    end

    // add_in1 is already the effective (possibly inverted) operand B.
    assign w_v_raw = (add_in0[15] == add_in1[15]) &
                     (add_sum[15] != add_in0[15]);
    assign w_c     = add_cout ^ (w_sub & SUB_BORROW);

    always_comb begin
        w_res16 = add_sum;
        if (w_sat & w_v_raw) begin
            w_res16 = add_in0[15] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_req_legal ? S_EXEC_LO : S_RESP;
                end
            end
            S_EXEC_LO: w_next = w_wide ? S_EXEC_HI : S_RESP;
            S_EXEC_HI: w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_lo_sum  <= 16'h0;
            r_lo_cout <= 1'b0;
            r_cflag   <= CFLAG_INIT;
            r_result  <= 32'h0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_v       <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_a  <= req_a;
                        r_b  <= req_b;
                        if (!w_req_legal) begin
                            r_result <= 32'h0;
                            r_c      <= 1'b0;
                            r_z      <= 1'b0;
                            r_n      <= 1'b0;
                            r_v      <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_EXEC_LO: begin
                    r_lo_sum  <= add_sum;
                    r_lo_cout <= add_cout;
                    if (!w_wide) begin
                        r_result <= {16'h0000, w_res16};
                        r_c      <= w_c;
                        r_z      <= (w_res16 == 16'h0000);
                        r_n      <= w_res16[15];
                        r_v      <= w_v_raw;
                        r_err    <= 1'b0;
                        r_cflag  <= w_c;
                    end
                end
                S_EXEC_HI: begin
                    r_result <= {add_sum, r_lo_sum};
                    r_c      <= w_c;
                    r_z      <= (add_sum == 16'h0000) &
                                (r_lo_sum == 16'h0000);
                    r_n      <= add_sum[15];
                    r_v      <= w_v_raw;
                    r_err    <= 1'b0;
                    r_cflag  <= w_c;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_result = r_result;
    assign rsp_c      = r_c;
    assign rsp_z      = r_z;
    assign rsp_n      = r_n;
    assign rsp_v      = r_v;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_add_seq.sv
// tb_alu_add_seq: directed table + random ops against a behavioural model,
// with a behavioural 16-bit adder closing the add_* loop.
module tb_alu_add_seq;

    localparam logic CI = 1'b0;
    localparam logic SB = 1'b0;
`ifdef ALU_ADD_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic [15:0] add_in0;
    logic [15:0] add_in1;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_c, rsp_z, rsp_n, rsp_v, rsp_err;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_in0} + {1'b0, add_in1} +
                                 {16'h0000, add_cin};

    alu_add_seq #(.CFLAG_INIT(CI), .SUB_BORROW(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v),
        .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] res;
        logic        c, z, n, v, err;
        int          lat;
    } out_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] res;
        logic        c, z, n, v, err;
        int          lat;
        logic        cin_hi;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    logic m_cflag = CI;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t g, input out_t e);
        chk({tag, ".res"}, g.res, e.res);
        chk({tag, ".c"}, {31'b0, g.c}, {31'b0, e.c});
        chk({tag, ".z"}, {31'b0, g.z}, {31'b0, e.z});
        chk({tag, ".n"}, {31'b0, g.n}, {31'b0, e.n});
        chk({tag, ".v"}, {31'b0, g.v}, {31'b0, e.v});
        chk({tag, ".err"}, {31'b0, g.err}, {31'b0, e.err});
        chk({tag, ".lat"}, g.lat, e.lat);
    endtask

    // Reference: whole-width arithmetic; updates the carry flag like the DUT.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output out_t o);
        logic        sub, cin, co, ovf;
        logic [31:0] bb, r;
        logic [32:0] s;
        o = '{default: '0};
        if (op >= 3'd6 && !SAT) begin
            o.err = 1'b1;
            o.lat = 1;
            return;
        end
        sub = (op == 3'd1 || op == 3'd3 || op == 3'd5 || op == 3'd7);
        case (op)
            3'd0, 3'd4, 3'd6: cin = 1'b0;
            3'd1, 3'd5, 3'd7: cin = 1'b1;
            3'd2:             cin = m_cflag;
            default:          cin = SB ? ~m_cflag : m_cflag;
        endcase
        bb = sub ? ~b : b;
        if (op == 3'd4 || op == 3'd5) begin
            s   = {1'b0, a} + {1'b0, bb} + 33'(cin);
            r   = s[31:0];
            co  = s[32];
            ovf = (a[31] == bb[31]) && (r[31] != a[31]);
            o.n = r[31];
            o.lat = 3;
        end else begin
            s   = {17'b0, a[15:0]} + {17'b0, bb[15:0]} + 33'(cin);
            r   = {16'h0, s[15:0]};
            co  = s[16];
            ovf = (a[15] == bb[15]) && (r[15] != a[15]);
            if (op >= 3'd6 && ovf) r = a[15] ? 32'h8000 : 32'h7FFF;
            o.n = r[15];
            o.lat = 2;
        end
        o.res = r;
        o.v   = ovf;
        o.z   = (r == 32'h0);
        o.c   = co ^ (sub & SB);
        m_cflag = o.c;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output out_t g, output logic cin_hi);
        int lat;
        g = '{default: '0};
        cin_hi = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) cin_hi = add_cin;
        end while (!rsp_valid && lat < 8);
        g.lat = lat;
        g.res = rsp_result;
        g.c = rsp_c; g.z = rsp_z; g.n = rsp_n; g.v = rsp_v;
        g.err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_result", rsp_result, g.res);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    vec_t tv[10];
    out_t g, e;
    logic cin_hi;
    logic [31:0] sp[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Expectations assume CFLAG_INIT=0, SUB_BORROW=0; order matters
        // because ADC/SBB consume the carry left by the previous entry.
        tv[0] = '{3'd0, 32'hFFFF, 32'h1, 32'h0, 1, 1, 0, 0, 0, 2, 0};
        tv[1] = '{3'd1, 32'h5, 32'h7, 32'hFFFE, 0, 0, 1, 0, 0, 2, 0};
        tv[2] = '{3'd0, 32'h8000, 32'h8000, 32'h0, 1, 1, 0, 1, 0, 2, 0};
`ifdef ALU_ADD_SEQ_SAT_EN
        tv[3] = '{3'd6, 32'h7FFF, 32'h1, 32'h7FFF, 0, 0, 0, 1, 0, 2, 0};
        tv[4] = '{3'd2, 32'h1, 32'h1, 32'h2, 0, 0, 0, 0, 0, 2, 0};
`else
        tv[3] = '{3'd6, 32'h7FFF, 32'h1, 32'h0, 0, 0, 0, 0, 1, 1, 0};
        tv[4] = '{3'd2, 32'h1, 32'h1, 32'h3, 0, 0, 0, 0, 0, 2, 0};
`endif
        tv[5] = '{3'd4, 32'hFFFF, 32'h1, 32'h10000, 0, 0, 0, 0, 0, 3, 1};
        tv[6] = '{3'd5, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 3, 0};
        tv[7] = '{3'd4, 32'h7FFFFFFF, 32'h1, 32'h80000000,
                  0, 0, 1, 1, 0, 3, 1};
        tv[8] = '{3'd1, 32'hABCD8000, 32'h12340001, 32'h7FFF,
                  1, 0, 0, 1, 0, 2, 0};
        tv[9] = '{3'd3, 32'h10, 32'h1, 32'hF, 1, 0, 0, 0, 0, 2, 0};
        sp = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
               32'h0000FFFF, 32'h00008000, 32'h00007FFF};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_flags", {27'b0, rsp_c, rsp_z, rsp_n, rsp_v, rsp_err}, 32'h0);
        chk("rst_adder", {15'b0, add_in0, add_cin}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            model(tv[i].op, tv[i].a, tv[i].b, e);
            do_op(tv[i].op, tv[i].a, tv[i].b, 0, g, cin_hi);
            e = '{tv[i].res, tv[i].c, tv[i].z, tv[i].n, tv[i].v,
                  tv[i].err, tv[i].lat};
            chk_out($sformatf("tv%0d", i), g, e);
            if (tv[i].lat == 3)
                chk($sformatf("tv%0d.cin_hi", i), {31'b0, cin_hi},
                    {31'b0, tv[i].cin_hi});
        end

        model(3'd0, 32'h1111, 32'h2222, e);
        do_op(3'd0, 32'h1111, 32'h2222, 5, g, cin_hi);
        chk("bp.res", g.res, 32'h3333);
        chk_out("bp", g, e);

        // Leave cflag=1, then reset in EXEC_HI of an op whose high pass
        // has carry-in 1.
        model(3'd0, 32'hFFFF, 32'h1, e);
        do_op(3'd0, 32'hFFFF, 32'h1, 0, g, cin_hi);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd4;
        req_a = 32'h0000FFFF;
        req_b = 32'h1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_cin_hi", {31'b0, add_cin}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_adder", {15'b0, add_in0, add_cin}, 32'h0);
        @(negedge clk);
        chk("rst_mid_valid2", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        m_cflag = CI;
        model(3'd2, 32'h0, 32'h0, e);
        do_op(3'd2, 32'h0, 32'h0, 0, g, cin_hi);
        chk("rst_cflag", g.res, {31'b0, CI});
        chk_out("rst_adc", g, e);

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(7));
            a = ($urandom_range(3) == 0) ? sp[$urandom_range(6)] : $urandom;
            b = ($urandom_range(3) == 0) ? sp[$urandom_range(6)] : $urandom;
            model(op, a, b, e);
            do_op(op, a, b, $urandom_range(2), g, cin_hi);
            chk_out($sformatf("rnd%0d_op%0d", i, op), g, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
